// File: rtl/key_entry_pkg.sv
// Shared key codes, state encodings and keypad map for the timer key entry path.
package key_entry_pkg;

    localparam logic [3:0] KEY_0      = 4'd0;
    localparam logic [3:0] KEY_1      = 4'd1;
    localparam logic [3:0] KEY_2      = 4'd2;
    localparam logic [3:0] KEY_3      = 4'd3;
    localparam logic [3:0] KEY_4      = 4'd4;
    localparam logic [3:0] KEY_5      = 4'd5;
    localparam logic [3:0] KEY_6      = 4'd6;
    localparam logic [3:0] KEY_7      = 4'd7;
    localparam logic [3:0] KEY_8      = 4'd8;
    localparam logic [3:0] KEY_9      = 4'd9;
    localparam logic [3:0] KEY_ENTER  = 4'd10;
    localparam logic [3:0] KEY_CLEAR  = 4'd11;
    localparam logic [3:0] KEY_IGNORE = 4'd12;
    localparam logic [3:0] KEY_NONE   = 4'd15;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO,
        ST_SETUP,
        ST_SEND
    } entry_state_t;

    typedef enum logic {
        DB_IDLE,
        DB_HELD
    } db_state_t;

    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = KEY_1;
            4'h1:    code = KEY_2;
            4'h2:    code = KEY_3;
            4'h4:    code = KEY_4;
            4'h5:    code = KEY_5;
            4'h6:    code = KEY_6;
            4'h8:    code = KEY_7;
            4'h9:    code = KEY_8;
            4'hA:    code = KEY_9;
            4'hC:    code = KEY_CLEAR;
            4'hD:    code = KEY_0;
            4'hE:    code = KEY_ENTER;
            default: code = KEY_IGNORE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// 4x4 keypad row scanner with column synchronizer and full-scan debouncer.
module keypad_scan
    import key_entry_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       key_evt,
    output logic [3:0] key_code
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [3:0]    col_s1, col_s2;
    logic [DW-1:0] div_cnt;
    logic [1:0]    row;
    logic [1:0]    acc_hits, row_hits, base_hits, tot_hits;
    logic [3:0]    acc_code, row_code, base_code, tot_code, result;
    logic          slot_end, scan_done;

    db_state_t     db_state, db_state_d;
    logic [CW-1:0] db_cnt, db_cnt_d;
    logic [3:0]    db_code, db_code_d;
    logic          evt_d;

    assign row_n     = ~(4'b0001 << row);
    assign slot_end  = (div_cnt == DW'(SCAN_DIV - 1));
    assign scan_done = slot_end && (row == 2'd3);
    assign key_code  = db_code;

    // Hit counts saturate at 2, which stands for MULTI.
    always_comb begin
        row_hits = '0;
        row_code = KEY_NONE;
        for (int unsigned c = 0; c < 4; c++) begin
            if (!col_s2[c]) begin
                if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
                if (row_code == KEY_NONE) row_code = keymap(row, 2'(c));
            end
        end
        base_hits = (row == 2'd0) ? 2'd0 : acc_hits;
        base_code = (row == 2'd0) ? KEY_NONE : acc_code;
        tot_hits  = (base_hits + row_hits > 2'd2) ? 2'd2 : base_hits + row_hits;
        tot_code  = (base_hits == 2'd0) ? row_code : base_code;
        result    = (tot_hits == 2'd1) ? tot_code : KEY_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_s1   <= '0;
            col_s2   <= '0;
            div_cnt  <= '0;
            row      <= '0;
            acc_hits <= '0;
            acc_code <= KEY_NONE;
        end else begin
            col_s1 <= col_n;
            col_s2 <= col_s1;
            if (slot_end) begin
                div_cnt  <= '0;
                row      <= row + 2'd1;
                acc_hits <= tot_hits;
                acc_code <= tot_code;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // A-D keys qualify and need a release like any key, but raise no event.
    always_comb begin
        db_state_d = db_state;
        db_cnt_d   = db_cnt;
        db_code_d  = db_code;
        evt_d      = 1'b0;
        if (scan_done) begin
            case (db_state)
                DB_IDLE: begin
                    if (result == KEY_NONE) begin
                        db_cnt_d = '0;
                    end else begin
                        db_cnt_d  = (result == db_code && db_cnt != '0) ? db_cnt + CW'(1) : CW'(1);
                        db_code_d = result;
                        if (db_cnt_d == CW'(DEBOUNCE)) begin
                            db_state_d = DB_HELD;
                            db_cnt_d   = '0;
                            evt_d      = (result != KEY_IGNORE);
                        end
                    end
                end
                DB_HELD: begin
                    if (result == KEY_NONE) begin
                        db_cnt_d = db_cnt + CW'(1);
                        if (db_cnt_d == CW'(DEBOUNCE)) begin
                            db_state_d = DB_IDLE;
                            db_cnt_d   = '0;
                        end
                    end else begin
                        db_cnt_d = '0;
                    end
                end
                default: db_state_d = DB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_state <= DB_IDLE;
            db_cnt   <= '0;
            db_code  <= KEY_NONE;
            key_evt  <= 1'b0;
        end else begin
            db_state <= db_state_d;
            db_cnt   <= db_cnt_d;
            db_code  <= db_code_d;
            key_evt  <= evt_d;
        end
    end

endmodule

// File: rtl/key_entry.sv
// Keypad front end: two-digit entry buffer and flag strobe toward the digit validator.
module key_entry
    import key_entry_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    parameter int FLAG_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] f_num,
    output logic [3:0] l_num,
    output logic       flag,
    output logic [3:0] disp_f,
    output logic [3:0] disp_l,
    output logic       busy
);

    localparam int FW = $clog2(FLAG_LEN + 1);

    logic          key_evt;
    logic [3:0]    key_code;
    entry_state_t  state, state_d;
    logic [FW-1:0] flag_cnt, flag_cnt_d;
    logic [3:0]    f_num_d, l_num_d, disp_f_d, disp_l_d;
    logic          flag_d, busy_d;

    keypad_scan #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_evt  (key_evt),
        .key_code (key_code)
    );

    always_comb begin
        state_d    = state;
        flag_cnt_d = flag_cnt;
        f_num_d    = f_num;
        l_num_d    = l_num;
        disp_f_d   = disp_f;
        disp_l_d   = disp_l;
        case (state)
            ST_EMPTY, ST_ONE, ST_TWO: begin
                if (key_evt) begin
                    if (key_code == KEY_ENTER) begin
                        f_num_d = disp_f;
                        l_num_d = disp_l;
                        state_d = ST_SETUP;
                    end else if (key_code == KEY_CLEAR) begin
                        disp_f_d = '0;
                        disp_l_d = '0;
                        state_d  = ST_EMPTY;
                    end else if (key_code <= KEY_9) begin
                        if (state == ST_EMPTY) begin
                            disp_f_d = '0;
                            disp_l_d = key_code;
                            state_d  = ST_ONE;
                        end else if (state == ST_ONE) begin
                            disp_f_d = disp_l;
                            disp_l_d = key_code;
                            state_d  = ST_TWO;
                        end
                    end
                end
            end
            ST_SETUP: begin
                flag_cnt_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (flag_cnt == FW'(FLAG_LEN - 1)) begin
                    disp_f_d = '0;
                    disp_l_d = '0;
                    state_d  = ST_EMPTY;
                end else begin
                    flag_cnt_d = flag_cnt + FW'(1);
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Strobe and busy are registered from the next state so they align with it.
        flag_d = (state_d == ST_SEND);
        busy_d = (state_d == ST_SETUP) || (state_d == ST_SEND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            flag_cnt <= '0;
            f_num    <= '0;
            l_num    <= '0;
            disp_f   <= '0;
            disp_l   <= '0;
            flag     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            flag_cnt <= flag_cnt_d;
            f_num    <= f_num_d;
            l_num    <= l_num_d;
            disp_f   <= disp_f_d;
            disp_l   <= disp_l_d;
            flag     <= flag_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_key_entry.sv
// Directed bench for key_entry driving a modelled 4x4 keypad matrix.
module tb_key_entry;

    localparam int K1 = 0, K2 = 1, K3 = 2, K4 = 4, K5 = 5, K6 = 6;
    localparam int K7 = 8, K8 = 9, K9 = 10, KSTAR = 12, KHASH = 14;
    localparam int SCAN = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_n, row_n, f_num, l_num, disp_f, disp_l;
    logic       flag, busy;
    logic [15:0] pressed = '0;

    int tests = 0;
    int fails = 0;
    int flag_rises = 0;

    always #5 clk = ~clk;

    key_entry #(.SCAN_DIV(4), .DEBOUNCE(2), .FLAG_LEN(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .col_n  (col_n),
        .row_n  (row_n),
        .f_num  (f_num),
        .l_num  (l_num),
        .flag   (flag),
        .disp_f (disp_f),
        .disp_l (disp_l),
        .busy   (busy)
    );

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_n[r])
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) col_n[c] = 1'b0;
    end

    always @(posedge flag) flag_rises++;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(negedge clk);
    endtask

    task automatic tap(input int k);
        pressed = 16'(1) << k;
        wait_scans(4);
        pressed = '0;
        wait_scans(4);
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (busy) ok = 1'b1;
        end
    endtask

    task automatic do_enter(input string tag, input logic [3:0] ef, input logic [3:0] el,
                            input logic [15:0] during_send);
        bit ok;
        pressed = 16'(1) << KHASH;
        wait_busy(ok);
        check({tag, "_busy"}, 8'(ok), 8'd1);
        if (ok) begin
            check({tag, "_setup_flag"}, 8'(flag), 8'd0);
            check({tag, "_f_num"}, 8'(f_num), 8'(ef));
            check({tag, "_l_num"}, 8'(l_num), 8'(el));
            for (int unsigned k = 0; k < 3; k++) begin
                @(negedge clk);
                if (k == 0 && during_send != '0) pressed = during_send;
                check({tag, "_flag_hi"}, 8'(flag), 8'd1);
                check({tag, "_hold_f"}, 8'(f_num), 8'(ef));
            end
            @(negedge clk);
            check({tag, "_flag_lo"}, 8'(flag), 8'd0);
            check({tag, "_busy_lo"}, 8'(busy), 8'd0);
            check({tag, "_clr"}, {disp_f, disp_l}, 8'h00);
        end
        wait_scans(4);
        pressed = '0;
        wait_scans(4);
    endtask

    initial begin
        bit ok;
        int rises;

        repeat (3) @(negedge clk);
        check("rst_row_n", 8'(row_n), 8'h0E);
        check("rst_nums", {f_num, l_num}, 8'h00);
        check("rst_disp", {disp_f, disp_l}, 8'h00);
        check("rst_flag_busy", {6'd0, flag, busy}, 8'h00);
        reset = 1'b0;

        do_enter("enter_empty", 4'd0, 4'd0, '0);

        tap(K4);
        tap(K5);
        check("disp_45", {disp_f, disp_l}, 8'h45);
        do_enter("send_45", 4'd4, 4'd5, '0);

        tap(K7);
        check("disp_07", {disp_f, disp_l}, 8'h07);
        do_enter("send_07", 4'd0, 4'd7, '0);

        tap(K1);
        tap(K2);
        tap(K3);
        check("disp_12_third_ignored", {disp_f, disp_l}, 8'h12);
        do_enter("send_12", 4'd1, 4'd2, '0);

        // one bounced scan, one open scan, then a long stable hold
        pressed = 16'(1) << K8;
        wait_scans(1);
        pressed = '0;
        wait_scans(1);
        pressed = 16'(1) << K8;
        wait_scans(10);
        pressed = '0;
        wait_scans(4);
        check("bounce_disp_8", {disp_f, disp_l}, 8'h08);
        tap(K9);
        check("bounce_single_evt", {disp_f, disp_l}, 8'h89);

        rises = flag_rises;
        tap(KSTAR);
        check("clear_disp", {disp_f, disp_l}, 8'h00);
        check("clear_no_flag", 8'(flag_rises - rises), 8'd0);

        pressed = (16'(1) << K1) | (16'(1) << K2);
        wait_scans(6);
        pressed = '0;
        wait_scans(4);
        check("multi_no_evt", {disp_f, disp_l}, 8'h00);

        tap(K6);
        check("disp_06", {disp_f, disp_l}, 8'h06);
        do_enter("send_06_key3", 4'd0, 4'd6, 16'(1) << K3);
        check("key3_dropped", {disp_f, disp_l}, 8'h00);

        tap(K5);
        tap(K6);
        pressed = 16'(1) << KHASH;
        wait_busy(ok);
        check("rst_send_busy", 8'(ok), 8'd1);
        @(negedge clk);
        @(negedge clk);
        check("rst_send_flag2", 8'(flag), 8'd1);
        check("rst_send_nums", {f_num, l_num}, 8'h56);
        reset = 1'b1;
        @(negedge clk);
        check("rst_send_flag", 8'(flag), 8'd0);
        check("rst_send_busy_lo", 8'(busy), 8'd0);
        check("rst_send_out", {f_num, l_num}, 8'h00);
        check("rst_send_row", 8'(row_n), 8'h0E);
        reset = 1'b0;
        pressed = '0;
        wait_scans(4);
        check("post_rst_disp", {disp_f, disp_l}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
